boot_loader: RTL

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 114 +++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Copies WORDS bootrom words into main memory at DEST_BASE, holding the CPU in reset
// until the copy completes; a memory write that is not accepted within TIMEOUT cycles aborts.
module boot_loader #(
    parameter int unsigned  WORDS     = 8,
    parameter logic [11:0]  DEST_BASE = 12'h000,
    parameter int unsigned  TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reboot,
    output logic        rom_cs,
    output logic        rom_we,
    output logic [3:0]  rom_addr,
    input  logic [15:0] rom_dout,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic        mem_ready,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, ROM_RD, MEM_WR, NEXT, DONE, ERR} state_t;

    localparam logic [3:0] LAST_IDX  = 4'(WORDS - 1);
    localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

    state_t     state;
    logic [3:0] index;
    logic [3:0] wait_cnt;
    logic       start;

    assign rom_we = 1'b0;

    always_comb begin
        start = (state == IDLE) || (((state == DONE) || (state == ERR)) && reboot);
    end

    // mem_din doubles as the captured-data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            index     <= '0;
            wait_cnt  <= '0;
            rom_cs    <= 1'b0;
            rom_addr  <= '0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else if (start) begin
            state     <= ROM_RD;
            index     <= '0;
            wait_cnt  <= '0;
            rom_cs    <= 1'b1;
            rom_addr  <= '0;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                ROM_RD: begin
                    state    <= MEM_WR;
                    rom_cs   <= 1'b0;
                    mem_din  <= rom_dout;
                    mem_addr <= DEST_BASE + {8'h00, index};
                    mem_cs   <= 1'b1;
                    mem_we   <= 1'b1;
                    wait_cnt <= '0;
                end
                MEM_WR: begin
                    if (mem_ready) begin
                        state    <= NEXT;
                        wait_cnt <= '0;
                        mem_cs   <= 1'b0;
                        mem_we   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                        if (wait_cnt == LAST_WAIT) begin
                            state  <= ERR;
                            mem_cs <= 1'b0;
                            mem_we <= 1'b0;
                            busy   <= 1'b0;
                            err    <= 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (index == LAST_IDX) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_rst_n <= 1'b1;
                    end else begin
                        state    <= ROM_RD;
                        index    <= index + 4'd1;
                        rom_addr <= index + 4'd1;
                        rom_cs   <= 1'b1;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule
